rsa_decrypt_core: RTL and testbench

Sequential modular-exponentiation stage downstream of the combinational RSA key-generation IP. It takes the modulus `n` and private exponent `d` that key-generation produces, buffers a burst of `NUM_MSG` ciphertexts, and computes each plaintext as `m = c^d mod n` by square-and-multiply, one exponent bit per cycle. It then streams the plaintexts out on consecutive cycles. It is the decrypt datapath of the RSA top level.

---
 rtl/rsa_decrypt_core.sv | 263 ++++++++++++++++++++++++++
 tb/tb_rsa_decrypt_core.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_decrypt_core.sv
// -----------------------------------------------------------------------------
// rsa_decrypt_core
//
// Burst-oriented RSA decrypt datapath. A burst of NUM_MSG ciphertexts is
// loaded together with the modulus n and private exponent d (both taken from
// the first accepted beat only). Each ciphertext is then turned into its
// plaintext m = c^d mod n by right-to-left square-and-multiply, one exponent
// bit per clock. The result overwrites the ciphertext slot. When every message
// is done, the plaintexts stream out on consecutive cycles in input order.
//
// Parameters
//   WIDTH    prime width; key, ciphertext and plaintext are 2*WIDTH bits
//   NUM_MSG  ciphertexts per burst
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset (aborts any burst)
//   in_valid   qualifies in_n / in_d / in_c
//   in_n       modulus, sampled on the first beat of a burst
//   in_d       private exponent, sampled with in_n
//   in_c       ciphertext, one per accepted beat
//   out_valid  registered; high for NUM_MSG consecutive cycles per burst
//   out_m      registered plaintext; forced to 0 while out_valid is low
// -----------------------------------------------------------------------------
module rsa_decrypt_core #(
  parameter int WIDTH   = 4,
  parameter int NUM_MSG = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [2*WIDTH-1:0]   in_n,
  input  logic [2*WIDTH-1:0]   in_d,
  input  logic [2*WIDTH-1:0]   in_c,
  output logic                 out_valid,
  output logic [2*WIDTH-1:0]   out_m
);

  localparam int KW = 2 * WIDTH;                               // key width
  localparam int PW = 4 * WIDTH;                               // product width
  localparam int IW = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;     // message index
  localparam int SW = (KW > 1) ? $clog2(KW) : 1;               // step counter

  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_MSG - 1);
  localparam logic [SW-1:0] LAST_STEP  = SW'(KW - 1);
  localparam logic [IW-1:0] IDX_ZERO   = {IW{1'b0}};
  localparam logic [IW-1:0] IDX_ONE    = {{(IW-1){1'b0}}, 1'b1};
  localparam logic [SW-1:0] STEP_ZERO  = {SW{1'b0}};
  localparam logic [SW-1:0] STEP_ONE   = {{(SW-1){1'b0}}, 1'b1};
  localparam logic [KW-1:0] KEY_ZERO   = {KW{1'b0}};
  localparam logic [KW-1:0] KEY_ONE    = {{(KW-1){1'b0}}, 1'b1};
  localparam bit            SINGLE_MSG = (NUM_MSG == 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CALC = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  // (a*b) mod m with the product held at full 4*WIDTH precision.
  function automatic logic [KW-1:0] mod_mul(input logic [KW-1:0] a,
                                            input logic [KW-1:0] b,
                                            input logic [KW-1:0] m);
    logic [PW-1:0] prod;
    prod    = PW'(a) * PW'(b);
    mod_mul = KW'(prod % PW'(m));
  endfunction

  // a mod m; lets ciphertexts at or above n enter the exponentiation.
  function automatic logic [KW-1:0] mod_red(input logic [KW-1:0] a,
                                            input logic [KW-1:0] m);
    mod_red = a % m;
  endfunction

  // Registered state
  state_t          state_r;
  logic [IW-1:0]   cnt_r;       // load slot pointer
  logic [IW-1:0]   msg_r;       // message under calculation / being output
  logic [SW-1:0]   step_r;      // exponent bit position within a message
  logic [KW-1:0]   n_r;
  logic [KW-1:0]   d_r;
  logic [KW-1:0]   res_r;
  logic [KW-1:0]   base_r;
  logic [KW-1:0]   exp_r;
  logic [KW-1:0]   c_r [NUM_MSG];

  // Next-state values
  state_t          state_s;
  logic [IW-1:0]   cnt_s;
  logic [IW-1:0]   msg_s;
  logic [SW-1:0]   step_s;
  logic [KW-1:0]   n_s;
  logic [KW-1:0]   d_s;
  logic [KW-1:0]   res_s;
  logic [KW-1:0]   base_s;
  logic [KW-1:0]   exp_s;
  logic            out_valid_s;
  logic [KW-1:0]   out_m_s;

  // Message buffer write port
  logic            c_we_s;
  logic [IW-1:0]   c_addr_s;
  logic [KW-1:0]   c_wdata_s;

  // Operands of the current square-and-multiply step
  logic [KW-1:0]   res_cur_s;
  logic [KW-1:0]   base_cur_s;
  logic [KW-1:0]   exp_cur_s;

  // Step-operand select: the first step of a message starts from the fresh
  // initial values directly, so no extra set-up cycle is spent per message.
  always_comb begin
    res_cur_s  = res_r;
    base_cur_s = base_r;
    exp_cur_s  = exp_r;
    if (step_r == STEP_ZERO) begin
      res_cur_s  = KEY_ONE;
      base_cur_s = mod_red(c_r[msg_r], n_r);
      exp_cur_s  = d_r;
    end else begin
      res_cur_s  = res_r;
      base_cur_s = base_r;
      exp_cur_s  = exp_r;
    end
  end

  // Next-state and output decode for the IDLE/LOAD/CALC/OUT sequencer.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    msg_s       = msg_r;
    step_s      = step_r;
    n_s         = n_r;
    d_s         = d_r;
    res_s       = res_r;
    base_s      = base_r;
    exp_s       = exp_r;
    out_valid_s = 1'b0;
    out_m_s     = KEY_ZERO;
    c_we_s      = 1'b0;
    c_addr_s    = IDX_ZERO;
    c_wdata_s   = KEY_ZERO;

    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          n_s       = in_n;
          d_s       = in_d;
          c_we_s    = 1'b1;
          c_addr_s  = IDX_ZERO;
          c_wdata_s = in_c;
          msg_s     = IDX_ZERO;
          step_s    = STEP_ZERO;
          if (SINGLE_MSG) begin
            cnt_s   = IDX_ZERO;
            state_s = ST_CALC;
          end else begin
            cnt_s   = IDX_ONE;
            state_s = ST_LOAD;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_LOAD: begin
        if (in_valid) begin
          c_we_s    = 1'b1;
          c_addr_s  = cnt_r;
          c_wdata_s = in_c;
          if (cnt_r == LAST_IDX) begin
            cnt_s   = IDX_ZERO;
            msg_s   = IDX_ZERO;
            step_s  = STEP_ZERO;
            state_s = ST_CALC;
          end else begin
            cnt_s   = cnt_r + IDX_ONE;
          end
        end else begin
          state_s = ST_LOAD;
        end
      end

      ST_CALC: begin
        // All 2*WIDTH exponent bits are always walked, even once exp is 0,
        // to keep the burst latency fixed.
        if (exp_cur_s[0]) begin
          res_s = mod_mul(res_cur_s, base_cur_s, n_r);
        end else begin
          res_s = res_cur_s;
        end
        base_s = mod_mul(base_cur_s, base_cur_s, n_r);
        exp_s  = exp_cur_s >> 1;
        if (step_r == LAST_STEP) begin
          c_we_s    = 1'b1;
          c_addr_s  = msg_r;
          c_wdata_s = res_s;
          step_s    = STEP_ZERO;
          if (msg_r == LAST_IDX) begin
            msg_s   = IDX_ZERO;
            state_s = ST_OUT;
          end else begin
            msg_s   = msg_r + IDX_ONE;
          end
        end else begin
          step_s = step_r + STEP_ONE;
        end
      end

      ST_OUT: begin
        out_valid_s = 1'b1;
        out_m_s     = c_r[msg_r];
        if (msg_r == LAST_IDX) begin
          msg_s   = IDX_ZERO;
          state_s = ST_IDLE;
        end else begin
          msg_s   = msg_r + IDX_ONE;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath, message buffer and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= IDX_ZERO;
      msg_r     <= IDX_ZERO;
      step_r    <= STEP_ZERO;
      n_r       <= KEY_ZERO;
      d_r       <= KEY_ZERO;
      res_r     <= KEY_ZERO;
      base_r    <= KEY_ZERO;
      exp_r     <= KEY_ZERO;
      out_valid <= 1'b0;
      out_m     <= KEY_ZERO;
      for (int i = 0; i < NUM_MSG; i++) begin
        c_r[i] <= KEY_ZERO;
      end
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      msg_r     <= msg_s;
      step_r    <= step_s;
      n_r       <= n_s;
      d_r       <= d_s;
      res_r     <= res_s;
      base_r    <= base_s;
      exp_r     <= exp_s;
      out_valid <= out_valid_s;
      out_m     <= out_m_s;
      if (c_we_s) begin
        c_r[c_addr_s] <= c_wdata_s;
      end
    end
  end

endmodule

// File: tb/tb_rsa_decrypt_core.sv
// -----------------------------------------------------------------------------
// tb_rsa_decrypt_core
//
// Scoreboard bench for rsa_decrypt_core. Each driven ciphertext pushes its
// expected plaintext; a negedge monitor pops and compares every out_valid beat,
// checks out_m is 0 when idle, checks burst length and load-to-output latency,
// and flags any output that has no pending expectation.
// -----------------------------------------------------------------------------
module tb_rsa_decrypt_core;

  localparam int WIDTH   = 4;
  localparam int NUM_MSG = 8;
  localparam int LAT     = NUM_MSG * 2 * WIDTH + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_n = 8'd0;
  logic [7:0] in_d = 8'd0;
  logic [7:0] in_c = 8'd0;
  logic       out_valid;
  logic [7:0] out_m;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         last_acc = 0;
  int         run = 0;
  logic       prev_v = 1'b0;
  logic [7:0] exp_q [$];
  logic [7:0] e_m;
  logic [7:0] cs [NUM_MSG];
  logic [7:0] ex [NUM_MSG];

  rsa_decrypt_core #(.WIDTH(WIDTH), .NUM_MSG(NUM_MSG)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_n      (in_n),
    .in_d      (in_d),
    .in_c      (in_c),
    .out_valid (out_valid),
    .out_m     (out_m)
  );

  // Free-running clock and edge counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Reference exponentiation by repeated multiplication.
  function automatic int ref_pow(input int c, input int d, input int n);
    int r;
    r = 1 % n;
    for (int i = 0; i < d; i++) r = (r * (c % n)) % n;
    return r;
  endfunction

  // Output monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      check_val("rst_out_valid", int'(out_valid), 0);
      check_val("rst_out_m", int'(out_m), 0);
      prev_v = 1'b0;
      run    = 0;
    end else begin
      if (out_valid) begin
        if (!prev_v) check_val("latency", cyc - last_acc, LAT);
        run++;
        if (exp_q.size() == 0) begin
          check_val("extra_out", 1, 0);
        end else begin
          e_m = exp_q.pop_front();
          check_val("out_m", int'(out_m), int'(e_m));
        end
      end else begin
        check_val("idle_out_m", int'(out_m), 0);
        if (prev_v) check_val("burst_len", run, NUM_MSG);
        run = 0;
      end
      prev_v = out_valid;
    end
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one burst; gaps of gmin..gmax idle cycles between beats, and
  // optionally random n/d on every beat after the first.
  task automatic drive_burst(input logic [7:0] n, input logic [7:0] d,
                             input logic [7:0] c_in [NUM_MSG],
                             input logic [7:0] e_in [NUM_MSG],
                             input int gmin, input int gmax, input bit scramble);
    for (int i = 0; i < NUM_MSG; i++) begin
      int g;
      g = (i == 0) ? 0 : int'($urandom_range(gmax, gmin));
      repeat (g) begin
        in_valid = 1'b0;
        in_n     = 8'($urandom);
        in_c     = 8'($urandom);
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_c     = c_in[i];
      if (i == 0 || !scramble) begin
        in_n = n;
        in_d = d;
      end else begin
        in_n = 8'($urandom);
        in_d = 8'($urandom);
      end
      exp_q.push_back(e_in[i]);
      @(posedge clk);
      #1;
      last_acc = cyc;
    end
    in_valid = 1'b0;
  endtask

  // Wait until the final beat of the burst is on the outputs; optionally
  // throw random in_valid pulses at the core while it is busy.
  task automatic wait_last(input bit junk);
    int k;
    for (k = 0; k < 2000; k++) begin
      if (out_valid && exp_q.size() == 1) break;
      if (junk) begin
        in_valid = 1'($urandom);
        in_c     = 8'($urandom);
        in_n     = 8'($urandom);
        in_d     = 8'($urandom);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (k == 2000) check_val("timeout", 0, 1);
  endtask

  task automatic fill_model(input int n, input int d);
    for (int i = 0; i < NUM_MSG; i++) ex[i] = 8'(ref_pow(int'(cs[i]), d, n));
  endtask

  task automatic set_basic();
    cs = '{8'd2, 8'd0, 8'd1, 8'd32, 8'd4, 8'd5, 8'd10, 8'd31};
    ex = '{8'd29, 8'd0, 8'd1, 8'd32, 8'd16, 8'd14, 8'd10, 8'd4};
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_out_valid", int'(out_valid), 0);
    check_val("reset_out_m", int'(out_m), 0);
    rst = 1'b0;
    idle(2);

    // Basic key n=33, d=7, contiguous burst
    set_basic();
    drive_burst(8'd33, 8'd7, cs, ex, 0, 0, 1'b0);
    wait_last(1'b0);
    idle(3);

    // n=35, d=5 with 1..3 cycle gaps; junk pulses during CALC/OUT
    for (int i = 0; i < NUM_MSG; i++) cs[i] = 8'(i + 2);
    fill_model(35, 5);
    ex[0] = 8'd32;
    ex[1] = 8'd33;
    drive_burst(8'd35, 8'd5, cs, ex, 1, 3, 1'b0);
    wait_last(1'b1);

    // Edge values (c >= n), key scrambled after first beat, back-to-back
    cs = '{8'd35, 8'd255, 8'd0, 8'd33, 8'd34, 8'd66, 8'd100, 8'd7};
    fill_model(33, 7);
    ex[0] = 8'd29;
    drive_burst(8'd33, 8'd7, cs, ex, 0, 0, 1'b1);
    wait_last(1'b1);

    // d = 0 gives 1 for every input
    cs = '{8'd4, 8'd0, 8'd34, 8'd35, 8'd200, 8'd1, 8'd2, 8'd3};
    fill_model(35, 0);
    ex[0] = 8'd1;
    drive_burst(8'd35, 8'd0, cs, ex, 0, 0, 1'b0);
    wait_last(1'b0);
    idle(2);

    // Reset in the middle of CALC, then a clean basic burst
    for (int i = 0; i < NUM_MSG; i++) cs[i] = 8'($urandom);
    fill_model(35, 5);
    drive_burst(8'd35, 8'd5, cs, ex, 0, 0, 1'b0);
    idle(30);
    rst = 1'b1;
    exp_q.delete();
    idle(3);
    rst = 1'b0;
    idle(1);
    set_basic();
    drive_burst(8'd33, 8'd7, cs, ex, 0, 0, 1'b0);
    wait_last(1'b0);

    // Back-to-back bursts with different keys
    for (int i = 0; i < NUM_MSG; i++) cs[i] = 8'($urandom);
    fill_model(35, 5);
    drive_burst(8'd35, 8'd5, cs, ex, 0, 2, 1'b0);
    wait_last(1'b0);
    for (int i = 0; i < NUM_MSG; i++) cs[i] = 8'($urandom);
    fill_model(55, 27);
    drive_burst(8'd55, 8'd27, cs, ex, 0, 0, 1'b0);
    wait_last(1'b0);
    idle(5);

    check_val("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
